gpmc_master: RTL
================

Name: gpmc_master

Overview:
- Synchronous-logic GPMC initiator that drives the multiplexed address/data bus (AD[15:0], nCS, nADV, nOE, nWE) toward a GPMC responder such as the FPGA-side target behind the FX2 connector.
- Used as the bus-cycle generator for loopback testing of the FPGA GPMC target, and as a reusable host model.
- Converts a simple valid/ready request port into asynchronous-mode, address/data-multiplexed single-word read or write cycles with parameterised timing and optional WAIT extension.

Parameters:
- ADV_CYCLES, 2, cycles nADV is held low with the address driven (min 1).
- ACCESS_CYCLES, 4, cycles nWE or nOE is held low (min 1).
- HOLD_CYCLES, 1, cycles nCS stays low after the strobe deasserts (min 1).
- TURN_CYCLES, 2, cycles nCS is high before the next cycle may start (min 1).
- USE_WAIT, 0, 1 enables wait_n extension of the access phase.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; the request is accepted on a clk edge where req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  16  word address placed on AD during the address phase
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_rdata  out  16  read data, held until the next read response
- ad_o  out  16  AD output value
- ad_oe  out  1  AD output enable (the top level builds the tristate)
- ad_i  in  16  AD input value
- ncs  out  1  chip select, active low
- nadv  out  1  address valid, active low
- noe  out  1  output enable, active low
- nwe  out  1  write enable, active low
- wait_n  in  1  responder wait, low = extend; ignored when USE_WAIT = 0

Behaviour:
- **Bus outputs.** All bus outputs and rsp_* are registered.
- **Reset values.** ncs = nadv = noe = nwe = 1, ad_oe = 0, ad_o = 0, rsp_valid = 0, rsp_rdata = 0, state = IDLE.
- **req_ready during reset.** req_ready = (state == IDLE), so it reads 1 during reset, but no request is accepted while rst_n = 0.
- **Request capture.** On acceptance, req_we, req_addr and req_wdata are captured into internal registers. Input changes after acceptance have no effect.
- **Phase counter.** A single down-counter, reloaded on each state entry, times every phase.
- **States:**
  - IDLE: all strobes high, ad_oe = 0. On accept, go to ADDR.
  - ADDR (ADV_CYCLES cycles): ncs = 0, nadv = 0, ad_oe = 1, ad_o = addr.
  - ADDR_HOLD (1 cycle): nadv = 1, ncs = 0, address still driven.
  - WR_ACCESS (ACCESS_CYCLES cycles): ad_o = wdata, ad_oe = 1, nwe = 0.
  - RD_ACCESS (ACCESS_CYCLES cycles): ad_oe = 0, noe = 0. ad_i is sampled into rsp_rdata on the clk edge that ends the final access cycle. rsp_valid = 1 for exactly the following cycle.
  - HOLD (HOLD_CYCLES cycles): nwe = noe = 1, ncs = 0. Write data stays driven; for reads ad_oe stays 0.
  - TURN (TURN_CYCLES cycles): ncs = 1, ad_oe = 0. Then go to IDLE.
- **Transaction length.** A transaction occupies ADV_CYCLES + 1 + ACCESS_CYCLES + HOLD_CYCLES + TURN_CYCLES cycles outside IDLE (10 at the defaults).
- **Back-to-back requests.** There is no pipelining. A request held valid continuously is accepted only on the first edge where state = IDLE again, giving a minimum 1 IDLE cycle between transactions.
- **WAIT extension (USE_WAIT = 1).** During the last access cycle, if wait_n = 0 the access state is held, strobes unchanged, and wait_n is re-checked each cycle. Read data is sampled on the edge where wait_n = 1 in the last access cycle. WAIT is unbounded and there is no timeout.
- **WAIT disabled (USE_WAIT = 0).** wait_n has no effect.
- **Reset mid-operation.** rst_n falling in any state returns all outputs to their reset values immediately (asynchronously). Any in-flight read produces no rsp_valid.
- **Address and data width.** The address is driven unmodified (no shift or increment); the full 16 bits are used.

Test Plan:
- **Reset values.** Assert rst_n = 0 with req_valid = 1 -> ncs/nadv/noe/nwe = 1, ad_oe = 0, rsp_valid = 0; no transaction starts before rst_n rises.
- **Default write.** Accept a write at edge 0 (addr 0x1234, data 0xBEEF) ->
  - edges 1–2: nadv = 0, ad_o = 0x1234
  - edge 3: nadv = 1
  - edges 4–7: nwe = 0, ad_o = 0xBEEF
  - edge 8: nwe = 1, ncs = 0
  - edges 9–10: ncs = 1
  - edge 11: req_ready = 1
- **Default read.** Read addr 0x0042 with the responder driving 0xA5A5 while noe = 0 -> ad_oe = 0 from edge 4; rsp_valid = 1 during cycle 8 only, with rsp_rdata = 0xA5A5.
- **Back-to-back.** Hold req_valid high for write then read -> the second accept occurs exactly at edge 11; the second nadv falls at edge 12; no overlap of ncs.
- **WAIT (USE_WAIT = 1).** Hold wait_n low for 3 cycles starting in the last access cycle -> noe stays low 3 extra cycles; data is sampled on the first wait_n = 1 edge; total transaction = 13 cycles.
- **Reset mid-read.** Drop rst_n during RD_ACCESS -> strobes high, ad_oe = 0 immediately; no rsp_valid; a normal read completes after rst_n is released.

Source files
------------

// File: rtl/gpmc_master.sv
// GPMC initiator: turns valid/ready requests into asynchronous, address/data
// multiplexed single-word read or write bus cycles with parameterised timing.
module gpmc_master #(
    parameter int unsigned ADV_CYCLES    = 2,
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned TURN_CYCLES   = 2,
    parameter int unsigned USE_WAIT      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] ad_o,
    output logic        ad_oe,
    input  logic [15:0] ad_i,
    output logic        ncs,
    output logic        nadv,
    output logic        noe,
    output logic        nwe,
    input  logic        wait_n
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_HOLD,
        WR_ACCESS,
        RD_ACCESS,
        HOLD,
        TURN
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        we_q;
    logic [15:0] wdata_q;
    logic        stall;
    logic        access_done;

    assign req_ready   = (state == IDLE);
    assign stall       = (USE_WAIT != 0) && !wait_n;
    // WAIT is only honoured once the nominal access time has elapsed.
    assign access_done = (cnt == '0) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ad_o      <= '0;
            ad_oe     <= 1'b0;
            ncs       <= 1'b1;
            nadv      <= 1'b1;
            noe       <= 1'b1;
            nwe       <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        ad_o    <= req_addr;
                        ad_oe   <= 1'b1;
                        ncs     <= 1'b0;
                        nadv    <= 1'b0;
                        cnt     <= 16'(ADV_CYCLES - 1);
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (cnt == '0) begin
                        nadv  <= 1'b1;
                        state <= ADDR_HOLD;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ADDR_HOLD: begin
                    cnt <= 16'(ACCESS_CYCLES - 1);
                    if (we_q) begin
                        ad_o  <= wdata_q;
                        nwe   <= 1'b0;
                        state <= WR_ACCESS;
                    end else begin
                        ad_oe <= 1'b0;
                        noe   <= 1'b0;
                        state <= RD_ACCESS;
                    end
                end
                WR_ACCESS: begin
                    if (access_done) begin
                        nwe   <= 1'b1;
                        cnt   <= 16'(HOLD_CYCLES - 1);
                        state <= HOLD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end
                end
                RD_ACCESS: begin
                    if (access_done) begin
                        rsp_rdata <= ad_i;
                        rsp_valid <= 1'b1;
                        noe       <= 1'b1;
                        cnt       <= 16'(HOLD_CYCLES - 1);
                        state     <= HOLD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        ncs   <= 1'b1;
                        ad_oe <= 1'b0;
                        cnt   <= 16'(TURN_CYCLES - 1);
                        state <= TURN;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                TURN: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
